// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, requester indices and defaults for the SRAM access arbiter.
package sram_arb_pkg;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 32;
    localparam logic [1:0] REQ_RC4 = 2'd0;
    localparam logic [1:0] REQ_SB = 2'd1;
    localparam logic [1:0] REQ_ED = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    function automatic logic [1:0] next3(input logic [1:0] i);
        return (i >= REQ_ED) ? REQ_RC4 : i + 2'd1;
    endfunction
endpackage

// File: rtl/sram_access_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker starting the search at ptr.
module rr_pick3
    import sram_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valid
);
    logic [1:0] p1, p2;
    assign p1 = next3(ptr);
    assign p2 = next3(p1);
    assign idx = req[ptr] ? ptr : (req[p1] ? p1 : p2);
    assign valid = |req;
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin share of the single SRAM port between RC4, sample-buffer fill and edge-detect writer.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int TO_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rc4_req,
    input  logic              rc4_wr,
    input  logic [ADDR_W-1:0] rc4_addr,
    input  logic [DATA_W-1:0] rc4_wdata,
    input  logic              sb_req,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              ed_req,
    input  logic [ADDR_W-1:0] ed_addr,
    input  logic [DATA_W-1:0] ed_wdata,
    output logic [2:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        owner,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_t state, state_next;
    logic [1:0] ptr, pick;
    logic pick_valid, timed_out, finish;
    logic [TO_W-1:0] cnt;

    rr_pick3 u_pick (
        .req  ({ed_req, sb_req, rc4_req}),
        .ptr  (ptr),
        .idx  (pick),
        .valid(pick_valid)
    );

    // the counter reaches TIMEOUT on this edge; a coincident mem_ready still wins
    assign timed_out = (cnt == TO_W'(TIMEOUT - 1));
    assign finish = mem_ready || timed_out;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pick_valid ? ISSUE : IDLE;
            ISSUE:   state_next = finish ? RESP : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done <= '0;
            rdata <= '0;
            err <= 1'b0;
            owner <= OWNER_NONE;
            busy <= 1'b0;
            mem_req <= 1'b0;
            mem_wr <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            ptr <= REQ_RC4;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    owner <= pick;
                    busy <= 1'b1;
                    mem_req <= 1'b1;
                    mem_wr <= (pick == REQ_RC4) ? rc4_wr : (pick == REQ_ED);
                    mem_addr <= (pick == REQ_RC4) ? rc4_addr : (pick == REQ_SB) ? sb_addr : ed_addr;
                    mem_wdata <= (pick == REQ_ED) ? ed_wdata : (pick == REQ_RC4) ? rc4_wdata : '0;
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        mem_req <= 1'b0;
                        done <= 3'b001 << owner;
                        err <= !mem_ready;
                        if (mem_ready && !mem_wr) rdata <= mem_rdata;
                    end
                end
                default: begin
                    done <= '0;
                    err <= 1'b0;
                    busy <= 1'b0;
                    cnt <= '0;
                    ptr <= next3(owner);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: table-driven and randomized checks of the SRAM arbiter against a transaction-level model.
module tb_sram_access_arbiter;
    import sram_arb_pkg::*;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic rc4_req, rc4_wr, sb_req, ed_req, mem_ready;
    logic [AW-1:0] rc4_addr, sb_addr, ed_addr;
    logic [DW-1:0] rc4_wdata, ed_wdata, mem_rdata;
    logic [2:0] done;
    logic [DW-1:0] rdata, mem_wdata;
    logic err, busy, mem_req, mem_wr;
    logic [1:0] owner;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .rc4_req(rc4_req), .rc4_wr(rc4_wr), .rc4_addr(rc4_addr), .rc4_wdata(rc4_wdata),
        .sb_req(sb_req), .sb_addr(sb_addr),
        .ed_req(ed_req), .ed_addr(ed_addr), .ed_wdata(ed_wdata),
        .done(done), .rdata(rdata), .err(err), .owner(owner), .busy(busy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;
    int txn_id = -1;
    logic [1:0] m_ptr;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic [2:0] req;
        logic       wr0;
        int         k;
        logic       hold;
        logic [1:0] win;
        logic       err;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d got %0h want %0h", name, txn_id, act, exp);
        end
    endtask

    // first requester at or after the pointer, wrapping mod 3
    function automatic logic [1:0] model_pick(input logic [2:0] r, input logic [1:0] p);
        for (int i = 0; i < 3; i++)
            if (r[(int'(p) + i) % 3]) return 2'((int'(p) + i) % 3);
        return 2'd3;
    endfunction

    // Called at a negedge with the arbiter idle; returns at a negedge with the arbiter idle again.
    task automatic run_txn(input logic [2:0] reqv, input logic wr0, input int k, input logic hold,
                           input logic [1:0] exp_win, input logic exp_err);
        logic [AW-1:0] a[3];
        logic [DW-1:0] wd[3];
        logic [DW-1:0] rd;
        logic exp_wr;
        int lat;
        for (int i = 0; i < 3; i++) begin
            a[i] = AW'($urandom);
            wd[i] = $urandom;
        end
        rd = $urandom;
        lat = (k < TO) ? k : TO - 1;
        exp_wr = (exp_win == 2'd0) ? wr0 : (exp_win == 2'd2);
        rc4_req = reqv[0];
        sb_req = reqv[1];
        ed_req = reqv[2];
        rc4_wr = wr0;
        rc4_addr = a[0];
        sb_addr = a[1];
        ed_addr = a[2];
        rc4_wdata = wd[0];
        ed_wdata = wd[2];
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, a[exp_win]);
            chk("mem_wr", mem_wr, exp_wr);
            if (exp_win != 2'd1) chk("mem_wdata", mem_wdata, wd[exp_win]);
            chk("busy", busy, 1);
            chk("owner", owner, exp_win);
            chk("done_early", done, 0);
            if (c == 0) begin
                if (!hold) {ed_req, sb_req, rc4_req} = 3'b000;
                rc4_addr = AW'($urandom);
                sb_addr = AW'($urandom);
                ed_addr = AW'($urandom);
                rc4_wdata = $urandom;
                ed_wdata = $urandom;
                rc4_wr = ~wr0;
            end
            if (c == lat && k < TO) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
        end
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!exp_wr && !exp_err) m_rdata = rd;
        chk("done", done, 3'b001 << exp_win);
        chk("err", err, exp_err);
        chk("rdata", rdata, m_rdata);
        chk("mem_req_drop", mem_req, 0);
        chk("busy_resp", busy, 1);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("done_clear", done, 0);
        chk("err_clear", err, 0);
        chk("busy_idle", busy, 0);
        chk("owner_keep", owner, exp_win);
        chk("rdata_keep", rdata, m_rdata);
        m_ptr = (exp_win == 2'd2) ? 2'd0 : exp_win + 2'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'b111, 1'b0, 1, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, 1'b0, 1, 1'b1, 2'd1, 1'b0};
        tbl[2]  = '{3'b111, 1'b0, 1, 1'b1, 2'd2, 1'b0};
        tbl[3]  = '{3'b111, 1'b0, 1, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{3'b010, 1'b0, 2, 1'b0, 2'd1, 1'b0};
        tbl[5]  = '{3'b100, 1'b0, 0, 1'b0, 2'd2, 1'b0};
        tbl[6]  = '{3'b001, 1'b0, 9, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{3'b001, 1'b0, 3, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{3'b101, 1'b0, 0, 1'b0, 2'd2, 1'b0};
        tbl[9]  = '{3'b011, 1'b1, 2, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{3'b110, 1'b0, 1, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{3'b011, 1'b0, 0, 1'b0, 2'd0, 1'b0};
        {rc4_req, rc4_wr, sb_req, ed_req, mem_ready} = '0;
        {rc4_addr, sb_addr, ed_addr} = '0;
        {rc4_wdata, ed_wdata, mem_rdata} = '0;
        #1 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_owner", owner, 3);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        n_rst = 1'b1;
        @(negedge clk);
        rc4_req = 1'b1;
        rc4_wr = 1'b1;
        rc4_addr = 20'h0ABCD;
        rc4_wdata = 32'hCAFE0001;
        @(negedge clk);
        chk("issue_mem_req", mem_req, 1);
        chk("issue_owner", owner, 0);
        rc4_req = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_owner", owner, 3);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_mem_addr", mem_addr, 0);
        @(negedge clk);
        n_rst = 1'b1;
        m_ptr = 2'd0;
        m_rdata = '0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_mem_req", mem_req, 0);
        for (int i = 0; i < 12; i++) begin
            txn_id = i;
            run_txn(tbl[i].req, tbl[i].wr0, tbl[i].k, tbl[i].hold, tbl[i].win, tbl[i].err);
        end
        for (int i = 0; i < 150; i++) begin
            logic [2:0] r;
            int k;
            txn_id = 100 + i;
            r = 3'($urandom_range(1, 7));
            k = $urandom_range(0, 6);
            run_txn(r, 1'($urandom_range(0, 1)), k, 1'($urandom_range(0, 1)),
                    model_pick(r, m_ptr), k >= TO);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single 32-bit SRAM port between three requesters.
  - RC4 decrypt engine: read/write.
  - Sample image data storage fill path: read only.
  - Edge-detection result writer: write only.
- Round-robin grant, one outstanding transaction at a time, bounded wait on the SRAM handshake.
- Sits between the datapath blocks and the SRAM/AHB master; generates the data-from-bus strobe consumed by sample_image_data_storage.

Parameters:
- ADDR_W, 20, byte/pixel address width (matches pixel-number width).
- DATA_W, 32, SRAM word width (4 pixels).
- TIMEOUT, 255, max cycles to wait for mem_ready before abort; must be >= 2 and < 2**TO_W.
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- rc4_req  in  1  RC4 engine request.
- rc4_wr  in  1  1=write, 0=read.
- rc4_addr  in  ADDR_W  RC4 address.
- rc4_wdata  in  DATA_W  RC4 write data.
- sb_req  in  1  sample-buffer fill read request.
- sb_addr  in  ADDR_W  read pixel number (SI_rpixNum).
- ed_req  in  1  edge-detect result write request.
- ed_addr  in  ADDR_W  write address.
- ed_wdata  in  DATA_W  write data.
- done  out  3  one-cycle completion pulse per requester [0]=rc4, [1]=sb, [2]=ed.
- rdata  out  DATA_W  read data, valid while done is high.
- err  out  1  one-cycle pulse with done when the transaction timed out.
- owner  out  2  current/last grant index; 3 = none.
- busy  out  1  transaction in flight.
- mem_req  out  1  SRAM request, held until mem_ready.
- mem_wr  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.
- mem_ready  in  1  SRAM completion, single-cycle.

Behaviour:
- Reset values:
  - done=0, rdata=0, err=0, owner=3, busy=0.
  - mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - RR pointer=0 (rc4 highest priority first), timeout counter=0.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is sampled high at edge N: pick the first requesting index at or after the RR pointer, modulo 3.
  - Latch addr/wdata/wr into the mem_* registers. Write enable per requester: rc4_wr for 0, 0 for 1, 1 for 2.
  - Set owner, busy=1, mem_req=1 from cycle N+1; go to ISSUE.
  - No req: stay, mem_req=0.
- ISSUE:
  - mem_* held stable; counter increments each cycle.
  - mem_ready sampled high: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), drop mem_req, go to RESP.
  - Counter reaches TIMEOUT without mem_ready: drop mem_req, set err for RESP, go to RESP.
- RESP (one cycle):
  - done[owner]=1, err as flagged; busy stays 1.
  - RR pointer = owner+1 mod 3; counter cleared.
  - Next state IDLE; busy=0, done=0, err=0 in the following cycle.
- Latency: req at edge N, mem_ready at edge N+1+k, done high in cycle N+2+k. Minimum 3 cycles req-to-done.
- Back-to-back: a requester holding req after done re-arbitrates in IDLE; the RR pointer guarantees others are served first. Worst-case wait is 2 other transactions.
- A req dropped while in ISSUE does not abort; the transaction completes and done still pulses.
- Requester inputs are not re-sampled after the IDLE latch; changing addr mid-transaction has no effect.
- mem_ready while in IDLE or RESP is ignored.
- mem_ready on the same edge the counter hits TIMEOUT: treat as success, err=0.
- Simultaneous reqs: strictly the RR order.
- Asynchronous reset mid-transaction drops mem_req immediately. No done is issued; the requester re-requests after reset.
- owner keeps the last grant between transactions (3 only after reset).

Decomposition:
- Shared package sram_arb_pkg holds:
  - typedef state_t {IDLE, ISSUE, RESP}.
  - Requester index constants REQ_RC4=0, REQ_SB=1, REQ_ED=2, OWNER_NONE=3.
  - Default ADDR_W/DATA_W.
- Sub-module rr_pick3: combinational 3-way round-robin picker taking the request vector and pointer, giving the granted index plus a valid flag.
- Timeout counter stays inline.

Test Plan:
- Reset: n_rst low mid-ISSUE (mem_req=1) -> all outputs at reset values immediately, owner=3, no done pulse.
- Single read: sb_req=1, sb_addr=20'h00040, mem_ready asserted 2 cycles after mem_req with mem_rdata=32'hA1B2C3D4 -> mem_wr=0, mem_addr=20'h00040, done=3'b010 exactly one cycle, rdata=32'hA1B2C3D4, err=0.
- Round-robin: all three req held high, mem_ready 1 cycle after each mem_req -> grants in order rc4, sb, ed, rc4; owner 0,1,2,0; each done a single pulse.
- Write path: ed_req, ed_addr=20'h12345, ed_wdata=32'h00FF00FF -> mem_wr=1, mem_wdata=32'h00FF00FF held until mem_ready, rdata unchanged, done[2] pulse.
- Timeout: TIMEOUT=4, rc4_req read, mem_ready never asserted -> mem_req high exactly 4 cycles, then done=3'b001 with err=1; next grant proceeds normally.
- Boundary: mem_ready coincident with the TIMEOUT cycle -> err=0, rdata captured. rc4_req dropped one cycle after grant -> transaction completes, done[0] still pulses.
